id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode-to-execute pipeline register of the 5-stage RISC-V core; directly consumes the register-file read ports RD1/RD2.
//  Captures operands, immediate, PC and control for EX; bypasses same-cycle WB writes into the captured operands.
//  Detects load-use hazards: stalls F/D and inserts an EX bubble.
// PARAMETERS
//  XLEN      32     datapath width (operands, imm, PC)
//  AW        5      register address width
//  LOAD_SRC  2'b01  result_src encoding that marks a load
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous, active-low reset (0 = reset)
//  rd1_d, rd2_d   in   XLEN  register-file read data (RD1/RD2)
//  rs1_d, rs2_d   in   AW    source register addresses in D
//  rd_d           in   AW    destination register address in D
//  imm_d          in   XLEN  sign-extended immediate
//  pc_d, pc4_d    in   XLEN  PC and PC+4 of the D instruction
//  reg_write_d    in   1     control: write back
//  result_src_d   in   2     control: 00 ALU, 01 load, 10 PC+4
//  mem_write_d    in   1     control: store
//  jump_d         in   1     control: jump
//  branch_d       in   1     control: branch
//  alu_ctrl_d     in   3     control: ALU op
//  alu_src_d      in   1     control: 1 = imm operand
//  reg_write_w    in   1     WB write enable (same as reg file WE3)
//  rd_w           in   AW    WB destination (A3)
//  result_w       in   XLEN  WB data (WD3)
//  flush_e        in   1     taken branch/jump in EX: squash D instruction
//  *_e outputs    out  —     registered copies of every *_d input above (same widths)
//  stall_fd       out  1     combinational: hold PC and IF/ID
// BEHAVIOUR
//  - Reset (rst=0, async): all *_e outputs 0 immediately (bubble = NOP, no writes); stall_fd follows its equation.
//  - Load-use: lu = reg_write_e & (result_src_e==LOAD_SRC) & (rd_e!=0) & ((rd_e==rs1_d)|(rd_e==rs2_d)).
//  - stall_fd = lu & ~flush_e (flush wins; squashed D needs no stall).
//  - At posedge, priority: rst > (flush_e | lu) > capture.
//  - flush_e|lu: all *_e control and data outputs load 0 (bubble).
//  - Capture: all *_e take their *_d values; latency exactly 1 cycle.
//  - WB bypass on capture: rd1_e = (reg_write_w & rd_w!=0 & rd_w==rs1_d) ? result_w : rd1_d; same for rd2_e/rs2_d.
//  - x0 never bypassed; rs1_d==rs2_d==rd_w bypasses both operands.
//  - Bubble lasts one cycle; the stalled D instruction is captured on the next edge with the load result available via bypass/forwarding.
//  - No internal state beyond the EX register; reset mid-stall clears lu on the next evaluation.
// TESTING
//  1 Reset: rst=0 with random inputs -> all *_e = 0, stall_fd=0; hold 0 until rst=1 and first edge.
//  2 Capture: rs1=5, rs2=6, rd1_d=6, rd2_d=0xA, imm=0x10, alu_src=1 -> next edge rd1_e=6, rd2_e=0xA, imm_e=0x10, alu_src_e=1.
//  3 WB bypass: rd_w=5, result_w=0x20, reg_write_w=1, rs1_d=5, rd1_d=6 -> rd1_e=0x20; repeat with rd_w=0 -> rd1_e=rd1_d.
//  4 Load-use: EX has lw x7 (result_src_e=01, rd_e=7), D add reads x7 -> stall_fd=1, next edge all *_e=0, then add captured.
//  5 Flush: flush_e=1 with valid D -> next edge reg_write_e=mem_write_e=0; flush_e & lu together -> stall_fd=0, bubble.
//  6 Async reset mid-op: drop rst between edges -> outputs zero without a clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with write-back bypass into the captured operands,
// and load-use hazard detection that stalls F/D and inserts a bubble into EX.
module id_ex_stage #(
  parameter int         XLEN     = 32,
  parameter int         AW       = 5,
  parameter logic [1:0] LOAD_SRC = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rd1_d,
  input  logic [XLEN-1:0] rd2_d,
  input  logic [AW-1:0]   rs1_d,
  input  logic [AW-1:0]   rs2_d,
  input  logic [AW-1:0]   rd_d,
  input  logic [XLEN-1:0] imm_d,
  input  logic [XLEN-1:0] pc_d,
  input  logic [XLEN-1:0] pc4_d,
  input  logic            reg_write_d,
  input  logic [1:0]      result_src_d,
  input  logic            mem_write_d,
  input  logic            jump_d,
  input  logic            branch_d,
  input  logic [2:0]      alu_ctrl_d,
  input  logic            alu_src_d,
  input  logic            reg_write_w,
  input  logic [AW-1:0]   rd_w,
  input  logic [XLEN-1:0] result_w,
  input  logic            flush_e,
  output logic [XLEN-1:0] rd1_e,
  output logic [XLEN-1:0] rd2_e,
  output logic [AW-1:0]   rs1_e,
  output logic [AW-1:0]   rs2_e,
  output logic [AW-1:0]   rd_e,
  output logic [XLEN-1:0] imm_e,
  output logic [XLEN-1:0] pc_e,
  output logic [XLEN-1:0] pc4_e,
  output logic            reg_write_e,
  output logic [1:0]      result_src_e,
  output logic            mem_write_e,
  output logic            jump_e,
  output logic            branch_e,
  output logic [2:0]      alu_ctrl_e,
  output logic            alu_src_e,
  output logic            stall_fd
);

  logic            lu_s;
  logic            bubble_s;
  logic [XLEN-1:0] byp1_s;
  logic [XLEN-1:0] byp2_s;

  // Load-use detection against the instruction currently in EX, plus stall.
  always_comb begin
    lu_s = 1'b0;
    if (reg_write_e && (result_src_e == LOAD_SRC) && (rd_e != {AW{1'b0}}) &&
        ((rd_e == rs1_d) || (rd_e == rs2_d))) begin
      lu_s = 1'b1;
    end else begin
      lu_s = 1'b0;
    end
    // A squashed D instruction never needs to be held.
    stall_fd = lu_s & ~flush_e;
    bubble_s = flush_e | lu_s;
  end

  // Same-cycle WB bypass; x0 is never forwarded.
  always_comb begin
    byp1_s = rd1_d;
    byp2_s = rd2_d;
    if (reg_write_w && (rd_w != {AW{1'b0}}) && (rd_w == rs1_d)) begin
      byp1_s = result_w;
    end else begin
      byp1_s = rd1_d;
    end
    if (reg_write_w && (rd_w != {AW{1'b0}}) && (rd_w == rs2_d)) begin
      byp2_s = result_w;
    end else begin
      byp2_s = rd2_d;
    end
  end

  // EX register: reset and bubble both load an all-zero NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd1_e        <= {XLEN{1'b0}};
      rd2_e        <= {XLEN{1'b0}};
      rs1_e        <= {AW{1'b0}};
      rs2_e        <= {AW{1'b0}};
      rd_e         <= {AW{1'b0}};
      imm_e        <= {XLEN{1'b0}};
      pc_e         <= {XLEN{1'b0}};
      pc4_e        <= {XLEN{1'b0}};
      reg_write_e  <= 1'b0;
      result_src_e <= 2'b00;
      mem_write_e  <= 1'b0;
      jump_e       <= 1'b0;
      branch_e     <= 1'b0;
      alu_ctrl_e   <= 3'b000;
      alu_src_e    <= 1'b0;
    end else if (bubble_s) begin
      rd1_e        <= {XLEN{1'b0}};
      rd2_e        <= {XLEN{1'b0}};
      rs1_e        <= {AW{1'b0}};
      rs2_e        <= {AW{1'b0}};
      rd_e         <= {AW{1'b0}};
      imm_e        <= {XLEN{1'b0}};
      pc_e         <= {XLEN{1'b0}};
      pc4_e        <= {XLEN{1'b0}};
      reg_write_e  <= 1'b0;
      result_src_e <= 2'b00;
      mem_write_e  <= 1'b0;
      jump_e       <= 1'b0;
      branch_e     <= 1'b0;
      alu_ctrl_e   <= 3'b000;
      alu_src_e    <= 1'b0;
    end else begin
      rd1_e        <= byp1_s;
      rd2_e        <= byp2_s;
      rs1_e        <= rs1_d;
      rs2_e        <= rs2_d;
      rd_e         <= rd_d;
      imm_e        <= imm_d;
      pc_e         <= pc_d;
      pc4_e        <= pc4_d;
      reg_write_e  <= reg_write_d;
      result_src_e <= result_src_d;
      mem_write_e  <= mem_write_d;
      jump_e       <= jump_d;
      branch_e     <= branch_d;
      alu_ctrl_e   <= alu_ctrl_d;
      alu_src_e    <= alu_src_d;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed D-stage vectors with hand-written
// expected EX contents and stall values, checked by decoupled monitors.
module tb_id_ex_stage;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        reg_write;
    logic [1:0]  result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic [2:0]  alu_ctrl;
    logic        alu_src;
  } bundle_t;

  logic        clk;
  logic        rst;
  bundle_t     din;
  logic        reg_write_w;
  logic [4:0]  rd_w;
  logic [31:0] result_w;
  logic        flush_e;

  logic [31:0] rd1_e, rd2_e, imm_e, pc_e, pc4_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e, stall_fd;
  logic [1:0]  result_src_e;
  logic [2:0]  alu_ctrl_e;

  int tests_run = 0;
  int tests_failed = 0;

  bundle_t exp_q[$];
  logic    stall_q[$];

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .rd1_d(din.rd1), .rd2_d(din.rd2), .rs1_d(din.rs1), .rs2_d(din.rs2), .rd_d(din.rd),
    .imm_d(din.imm), .pc_d(din.pc), .pc4_d(din.pc4),
    .reg_write_d(din.reg_write), .result_src_d(din.result_src), .mem_write_d(din.mem_write),
    .jump_d(din.jump), .branch_d(din.branch), .alu_ctrl_d(din.alu_ctrl), .alu_src_d(din.alu_src),
    .reg_write_w(reg_write_w), .rd_w(rd_w), .result_w(result_w), .flush_e(flush_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .imm_e(imm_e), .pc_e(pc_e), .pc4_e(pc4_e),
    .reg_write_e(reg_write_e), .result_src_e(result_src_e), .mem_write_e(mem_write_e),
    .jump_e(jump_e), .branch_e(branch_e), .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e),
    .stall_fd(stall_fd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bundle_t dut_e();
    bundle_t b;
    b = {rd1_e, rd2_e, rs1_e, rs2_e, rd_e, imm_e, pc_e, pc4_e, reg_write_e,
         result_src_e, mem_write_e, jump_e, branch_e, alu_ctrl_e, alu_src_e};
    return b;
  endfunction

  function automatic bundle_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] rd1,
                                 input logic [31:0] rd2, input logic [31:0] imm,
                                 input logic [31:0] pc, input logic rw,
                                 input logic [1:0] rsrc, input logic mw,
                                 input logic asrc);
    bundle_t b;
    b = '0;
    b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.rd1 = rd1; b.rd2 = rd2;
    b.imm = imm; b.pc = pc; b.pc4 = pc + 32'd4;
    b.reg_write = rw; b.result_src = rsrc; b.mem_write = mw;
    b.alu_ctrl = 3'b010; b.alu_src = asrc;
    return b;
  endfunction

  task automatic check_e(input string name, input bundle_t exp);
    bundle_t act;
    act = dut_e();
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_stall(input string name, input logic exp);
    tests_run++;
    if (stall_fd !== exp) begin
      tests_failed++;
      $display("FAIL %s: stall_fd got %b want %b", name, stall_fd, exp);
    end
  endtask

  // Drive one D-stage vector on the falling edge and queue its expectations.
  task automatic issue(input bundle_t d, input logic we, input logic [4:0] rdw,
                       input logic [31:0] res, input logic fl,
                       input bundle_t exp, input logic st);
    @(negedge clk);
    din = d; reg_write_w = we; rd_w = rdw; result_w = res; flush_e = fl;
    stall_q.push_back(st);
    exp_q.push_back(exp);
  endtask

  // Stall monitor: settled combinational value before the capturing edge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (stall_q.size() > 0) check_stall("stall", stall_q.pop_front());
    end
  end

  // EX register monitor: compared just after each capturing edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_e("ex_reg", exp_q.pop_front());
    end
  end

  initial begin
    bundle_t d, e, z;
    logic [191:0] r;
    z = '0;
    din = '0; reg_write_w = 1'b0; rd_w = 5'd0; result_w = 32'd0; flush_e = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check_e("reset_async", z);
    check_stall("reset_stall", 1'b0);

    // Random inputs while held in reset: EX stays zero.
    for (int i = 0; i < 3; i++) begin
      r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      issue(r[184:0], 1'b1, r[4:0], r[63:32], 1'b0, z, 1'b0);
    end
    @(negedge clk);
    #3;
    check_e("reset_hold", z);
    rst = 1'b1;

    // Plain capture.
    d = mk(5'd5, 5'd6, 5'd3, 32'd6, 32'hA, 32'h10, 32'h100, 1'b1, 2'b00, 1'b0, 1'b1);
    issue(d, 1'b0, 5'd0, 32'd0, 1'b0, d, 1'b0);

    // WB bypass of rs1.
    d = mk(5'd5, 5'd6, 5'd4, 32'd6, 32'hA, 32'h10, 32'h104, 1'b1, 2'b00, 1'b0, 1'b1);
    e = d; e.rd1 = 32'h20;
    issue(d, 1'b1, 5'd5, 32'h20, 1'b0, e, 1'b0);

    // rd_w = 0 never bypasses, even when rs1 is x0.
    d = mk(5'd0, 5'd6, 5'd4, 32'd6, 32'hA, 32'h14, 32'h108, 1'b1, 2'b00, 1'b0, 1'b0);
    issue(d, 1'b1, 5'd0, 32'h20, 1'b0, d, 1'b0);

    // rs1 == rs2 == rd_w bypasses both operands.
    d = mk(5'd9, 5'd9, 5'd4, 32'd1, 32'd2, 32'h0, 32'h10C, 1'b1, 2'b00, 1'b0, 1'b0);
    e = d; e.rd1 = 32'h55; e.rd2 = 32'h55;
    issue(d, 1'b1, 5'd9, 32'h55, 1'b0, e, 1'b0);

    // No bypass without reg_write_w; jump/branch captured.
    d = mk(5'd9, 5'd9, 5'd4, 32'd1, 32'd2, 32'h8, 32'h110, 1'b0, 2'b10, 1'b0, 1'b0);
    d.jump = 1'b1; d.branch = 1'b1; d.alu_ctrl = 3'b101;
    issue(d, 1'b0, 5'd9, 32'h55, 1'b0, d, 1'b0);

    // lw x7 enters EX.
    d = mk(5'd2, 5'd0, 5'd7, 32'h40, 32'd0, 32'h4, 32'h114, 1'b1, 2'b01, 1'b0, 1'b1);
    issue(d, 1'b0, 5'd0, 32'd0, 1'b0, d, 1'b0);

    // add reads x7: stall + bubble, then captured with the load result bypassed.
    d = mk(5'd7, 5'd8, 5'd10, 32'h0, 32'h3, 32'h0, 32'h118, 1'b1, 2'b00, 1'b0, 1'b0);
    issue(d, 1'b0, 5'd0, 32'd0, 1'b0, z, 1'b1);
    e = d; e.rd1 = 32'h77;
    issue(d, 1'b1, 5'd7, 32'h77, 1'b0, e, 1'b0);

    // lw x12, then consumer via rs2 with flush: flush wins, no stall, bubble.
    d = mk(5'd1, 5'd0, 5'd12, 32'h9, 32'd0, 32'h8, 32'h11C, 1'b1, 2'b01, 1'b0, 1'b1);
    issue(d, 1'b0, 5'd0, 32'd0, 1'b0, d, 1'b0);
    d = mk(5'd3, 5'd12, 5'd11, 32'h1, 32'h2, 32'h0, 32'h120, 1'b1, 2'b00, 1'b0, 1'b0);
    issue(d, 1'b0, 5'd0, 32'd0, 1'b1, z, 1'b0);

    // Flush of a valid store with no hazard.
    d = mk(5'd3, 5'd4, 5'd0, 32'h1, 32'h2, 32'hC, 32'h124, 1'b1, 2'b00, 1'b1, 1'b1);
    issue(d, 1'b0, 5'd0, 32'd0, 1'b1, z, 1'b0);

    // lw x0 never causes a stall; next instruction is itself lw x13.
    d = mk(5'd1, 5'd0, 5'd0, 32'h9, 32'd0, 32'h0, 32'h128, 1'b1, 2'b01, 1'b0, 1'b1);
    issue(d, 1'b0, 5'd0, 32'd0, 1'b0, d, 1'b0);
    d = mk(5'd0, 5'd0, 5'd13, 32'h0, 32'h0, 32'h4, 32'h12C, 1'b1, 2'b01, 1'b0, 1'b1);
    issue(d, 1'b0, 5'd0, 32'd0, 1'b0, d, 1'b0);

    // Consumer of x13 through rs2: stall, then capture.
    d = mk(5'd1, 5'd13, 5'd14, 32'h5, 32'h0, 32'h0, 32'h130, 1'b1, 2'b00, 1'b0, 1'b0);
    issue(d, 1'b0, 5'd0, 32'd0, 1'b0, z, 1'b1);
    issue(d, 1'b0, 5'd0, 32'd0, 1'b0, d, 1'b0);

    // Async reset between edges clears EX without a clock edge.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check_e("reset_midop", z);
    check_stall("reset_midop_stall", 1'b0);
    #2;
    rst = 1'b1;

    for (int i = 0; i < 5 && (exp_q.size() > 0 || stall_q.size() > 0); i++) @(posedge clk);
    #2;
    tests_run++;
    if (exp_q.size() != 0 || stall_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d ex / %0d stall entries left, want 0", exp_q.size(), stall_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
